tick_counter: RTL and testbench



---
 rtl/tick_counter_pkg.sv | 20 ++
 rtl/tick_counter_if.sv | 39 +++
 rtl/tick_counter_core.sv | 39 +++
 rtl/tick_counter.sv | 71 +++++++
 tb/tb_tick_counter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_counter_pkg.sv
// Shared types and constants for the programmable tick counter.
package tick_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 10 Hz tick from a 50 MHz board clock
  localparam longint unsigned DEFAULT_RESET_LIMIT = 64'd4999999;

  // Terminal value giving tick_hz ticks per second from clk_hz
  function automatic longint unsigned calc_limit(input longint unsigned clk_hz,
                                                 input longint unsigned tick_hz);
    if (tick_hz == 64'd0 || clk_hz < tick_hz) return 64'd0;
    return (clk_hz / tick_hz) - 64'd1;
  endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control/status bundle for tick_counter. Capture signals exist only with
// TICK_COUNTER_CAPTURE_EN defined.
interface tick_counter_if #(
  parameter int WIDTH = 32
);
  logic             i_enable;
  logic             i_clear;
  logic             i_limit_we;
  logic [WIDTH-1:0] i_limit;
  logic             i_oneshot;
  logic             i_start;
  logic [WIDTH-1:0] o_count;
  logic [WIDTH-1:0] o_limit;
  logic             o_tick;
  logic             o_busy;
  logic             o_done;
`ifdef TICK_COUNTER_CAPTURE_EN
  logic             i_capture;
  logic [WIDTH-1:0] o_capture;

  modport master (
    output i_enable, i_clear, i_limit_we, i_limit, i_oneshot, i_start, i_capture,
    input  o_count, o_limit, o_tick, o_busy, o_done, o_capture
  );
  modport slave (
    input  i_enable, i_clear, i_limit_we, i_limit, i_oneshot, i_start, i_capture,
    output o_count, o_limit, o_tick, o_busy, o_done, o_capture
  );
`else
  modport master (
    output i_enable, i_clear, i_limit_we, i_limit, i_oneshot, i_start,
    input  o_count, o_limit, o_tick, o_busy, o_done
  );
  modport slave (
    input  i_enable, i_clear, i_limit_we, i_limit, i_oneshot, i_start,
    output o_count, o_limit, o_tick, o_busy, o_done
  );
`endif
endinterface

// File: rtl/tick_counter_core.sv
// Count register with >= terminal compare, wrap and registered tick.
module tick_counter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_run_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick,
  output logic             o_wrap
);
  logic [WIDTH-1:0] count_q;
  logic             tick_q;

  // >= so a lowered limit wraps at once and the increment never overflows
  assign o_wrap = i_run_en && (count_q >= i_limit);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (i_clear) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (o_wrap) begin
      count_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      tick_q <= 1'b0;
      if (i_run_en) count_q <= count_q + WIDTH'(1);
    end
  end

  assign o_count = count_q;
  assign o_tick  = tick_q;

endmodule

// File: rtl/tick_counter.sv
// Programmable prescaler / tick source: FSM, limit register, optional capture.
// Optional capture port enabled by defining TICK_COUNTER_CAPTURE_EN.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter longint unsigned RESET_LIMIT = DEFAULT_RESET_LIMIT
) (
  input logic           i_clk,
  input logic           i_rstn,
  tick_counter_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] count;
  logic             run_en;
  logic             wrap;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.i_oneshot || bus.i_start) state_d = RUN;
      RUN:  if (wrap && bus.i_oneshot)         state_d = DONE;
      DONE: if (bus.i_start || !bus.i_oneshot) state_d = RUN;
      default:                                 state_d = IDLE;
    endcase
    if (bus.i_clear) state_d = IDLE;
  end

  // A write lands next cycle, so a same-cycle compare still sees the old limit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)             limit_q <= WIDTH'(RESET_LIMIT);
    else if (bus.i_limit_we) limit_q <= bus.i_limit;
  end

  assign run_en = (state_q == RUN) && bus.i_enable;

  tick_counter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (bus.i_clear),
    .i_run_en (run_en),
    .i_limit  (limit_q),
    .o_count  (count),
    .o_tick   (bus.o_tick),
    .o_wrap   (wrap)
  );

  assign bus.o_count = count;
  assign bus.o_limit = limit_q;
  assign bus.o_busy  = (state_q == RUN);
  assign bus.o_done  = (state_q == DONE);

`ifdef TICK_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] capture_q;

  // Samples the pre-update count, so a wrap cycle captures the limit value
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)            capture_q <= '0;
    else if (bus.i_capture) capture_q <= count;
  end

  assign bus.o_capture = capture_q;
`endif

endmodule

// File: tb/tb_tick_counter.sv
// Directed checks of tick_counter: default 32-bit instance plus a 4-bit instance.
module tb_tick_counter;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tick_counter_if #(.WIDTH(32)) b32 ();
  tick_counter_if #(.WIDTH(4))  b4  ();

  tick_counter #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rstn(rstn), .bus(b32.slave));
  tick_counter #(.WIDTH(4), .RESET_LIMIT(64'd6)) dut4 (.i_clk(clk), .i_rstn(rstn), .bus(b4.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_cnt [8];
    logic       exp_tck [8];
    exp_cnt = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0};
    exp_tck = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    b32.i_enable = 1'b1; b32.i_clear = 1'b0; b32.i_limit_we = 1'b0;
    b32.i_limit = '0;    b32.i_oneshot = 1'b0; b32.i_start = 1'b0;
    b4.i_enable = 1'b0;  b4.i_clear = 1'b0;  b4.i_limit_we = 1'b0;
    b4.i_limit = '0;     b4.i_oneshot = 1'b1; b4.i_start = 1'b0;
`ifdef TICK_COUNTER_CAPTURE_EN
    b32.i_capture = 1'b0;
    b4.i_capture  = 1'b0;
`endif

    #12;
    chk("rst32_limit", b32.o_limit, 64'd4999999);
    chk("rst32_count", b32.o_count, 64'd0);
    chk("rst4_limit",  b4.o_limit,  64'd6);
    chk("rst4_tick",   b4.o_tick,   64'd0);
    chk("rst4_busy",   b4.o_busy,   64'd0);
    chk("rst4_done",   b4.o_done,   64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // free-run 32-bit: RUN one cycle after release, then counts
    step();
    chk("f32_busy",  b32.o_busy,  64'd1);
    chk("f32_count", b32.o_count, 64'd0);
    chk("os4_idle",  b4.o_busy,   64'd0);
    step();
    chk("f32_count1", b32.o_count, 64'd1);

    // limit=3, enable toggling: 0,1,1,2,2,3,3,0
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd3;
    step();
    b4.i_limit_we = 1'b0;
    chk("wr3_limit", b4.o_limit, 64'd3);
    b4.i_oneshot = 1'b0;
    step();
    chk("fr_busy",  b4.o_busy,  64'd1);
    chk("fr_count", b4.o_count, 64'd0);
    for (int i = 0; i < 8; i++) begin
      b4.i_enable = (i % 2 == 0);
      step();
      chk($sformatf("tog_count%0d", i), b4.o_count, 64'(exp_cnt[i]));
      chk($sformatf("tog_tick%0d", i),  b4.o_tick,  64'(exp_tck[i]));
    end

    // limit 9, at count 7 the limit drops to 4
    b4.i_enable = 1'b1;
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd9;
    step();
    b4.i_limit_we = 1'b0;
    chk("l9_count1", b4.o_count, 64'd1);
    repeat (5) step();
    chk("l9_count6", b4.o_count, 64'd6);
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd4;
    step();
    b4.i_limit_we = 1'b0;
    chk("l4_count7", b4.o_count, 64'd7);
    chk("l4_limit",  b4.o_limit, 64'd4);
    step();
    chk("l4_wrap_count", b4.o_count, 64'd0);
    chk("l4_wrap_tick",  b4.o_tick,  64'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("l4_count%0d", k), b4.o_count, 64'(k));
      chk($sformatf("l4_tick%0d", k),  b4.o_tick,  64'd0);
    end
    step();
    chk("l4_period_tick", b4.o_tick, 64'd1);

    // one-shot limit=2, clear and limit write together
    b4.i_clear = 1'b1; b4.i_oneshot = 1'b1;
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd2;
    step();
    b4.i_clear = 1'b0; b4.i_limit_we = 1'b0;
    chk("clr_busy",  b4.o_busy,  64'd0);
    chk("clr_limit", b4.o_limit, 64'd2);
    step();
    chk("os_wait", b4.o_busy, 64'd0);
    b4.i_start = 1'b1;
    step();
    b4.i_start = 1'b0;
    chk("os_busy",   b4.o_busy,  64'd1);
    chk("os_count0", b4.o_count, 64'd0);
    step();
    chk("os_count1", b4.o_count, 64'd1);
    b4.i_start = 1'b1;
    step();
    b4.i_start = 1'b0;
    chk("os_ign_count", b4.o_count, 64'd2);
    chk("os_ign_busy",  b4.o_busy,  64'd1);
    step();
    chk("os_tick",  b4.o_tick,  64'd1);
    chk("os_done",  b4.o_done,  64'd1);
    chk("os_idle",  b4.o_busy,  64'd0);
    chk("os_count", b4.o_count, 64'd0);
    step();
    chk("os_done_hold", b4.o_done, 64'd1);
    chk("os_tick_once", b4.o_tick, 64'd0);
    b4.i_start = 1'b1;
    step();
    b4.i_start = 1'b0;
    chk("os2_busy", b4.o_busy, 64'd1);
    chk("os2_done", b4.o_done, 64'd0);
    repeat (2) step();
    chk("os2_count2", b4.o_count, 64'd2);
    step();
    chk("os2_tick", b4.o_tick, 64'd1);
    chk("os2_done", b4.o_done, 64'd1);

    // clear on the wrap cycle at count=limit=5
    b4.i_oneshot = 1'b0;
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd5;
    step();
    b4.i_limit_we = 1'b0;
    chk("l5_busy", b4.o_busy, 64'd1);
    repeat (5) step();
    chk("l5_count5", b4.o_count, 64'd5);
    b4.i_clear = 1'b1;
    step();
    b4.i_clear = 1'b0;
    chk("cw_count", b4.o_count, 64'd0);
    chk("cw_tick",  b4.o_tick,  64'd0);
    chk("cw_busy",  b4.o_busy,  64'd0);
    chk("cw_limit", b4.o_limit, 64'd5);
    step();
    chk("cw_rerun", b4.o_busy, 64'd1);
    repeat (2) step();
    chk("pre_rst_count", b4.o_count, 64'd2);

    // async reset mid-count, between edges
    #2 rstn = 1'b0;
    #1;
    chk("arst_count",   b4.o_count,  64'd0);
    chk("arst_limit",   b4.o_limit,  64'd6);
    chk("arst_busy",    b4.o_busy,   64'd0);
    chk("arst32_limit", b32.o_limit, 64'd4999999);
    chk("arst32_count", b32.o_count, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    chk("rerun_busy", b4.o_busy, 64'd1);

    // limit=15 on 4 bits: reach all-ones, wrap without overflow
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd15;
    step();
    b4.i_limit_we = 1'b0;
    repeat (14) step();
    chk("max_count15", b4.o_count, 64'd15);
`ifdef TICK_COUNTER_CAPTURE_EN
    b4.i_capture = 1'b1;
`endif
    step();
`ifdef TICK_COUNTER_CAPTURE_EN
    b4.i_capture = 1'b0;
    chk("cap_wrap", b4.o_capture, 64'd15);
`endif
    chk("max_wrap_count", b4.o_count, 64'd0);
    chk("max_wrap_tick",  b4.o_tick,  64'd1);

    // limit=0: tick every enabled cycle
    b4.i_limit_we = 1'b1; b4.i_limit = 4'd0;
    step();
    b4.i_limit_we = 1'b0;
    chk("l0_count1", b4.o_count, 64'd1);
    step();
    chk("l0_count_a", b4.o_count, 64'd0);
    chk("l0_tick_a",  b4.o_tick,  64'd1);
    step();
    chk("l0_count_b", b4.o_count, 64'd0);
    chk("l0_tick_b",  b4.o_tick,  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
